ushift_reg: RTL and testbench

USHIFT_REG -- requirements
Module: ushift_reg

---
 rtl/ushift_reg.sv | 73 +++++++
 tb/tb_ushift_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ushift_reg.sv
// ushift_reg: universal shift register with an automatic n-position shift sequencer.
// Define USHIFT_REG_ROTATE_EN to refill with the ejected bit (rotate) instead of sin.
module ushift_reg #(
  parameter int SIZE = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] dt,
  input  logic            sin,
  input  logic            start,
  input  logic            dir,
  input  logic [CNTW-1:0] n,
  output logic [SIZE-1:0] Q,
  output logic            sout,
  output logic            busy,
  output logic            done,
  output logic            zero
);
`ifdef USHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CNTW-1:0] cnt, cnt_nx;
  logic ldir, dir_nx, act_dir, fill;
  logic [SIZE-1:0] q_nx, shl, shr;
  // Outside RUN the direction comes from the op about to be applied
  assign act_dir = (state == RUN) ? ldir : (op == 2'b10);
  assign sout = act_dir ? Q[0] : Q[SIZE-1];
  assign fill = ROT ? sout : sin;
  assign shl = {Q[SIZE-2:0], fill};
  assign shr = {fill, Q[SIZE-1:1]};
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign zero = (Q == '0);
  always_comb begin
    state_nx = state;
    q_nx = Q;
    cnt_nx = cnt;
    dir_nx = ldir;
    case (state)
      IDLE:
        if (start) begin
          dir_nx = dir;
          cnt_nx = n;
          state_nx = (n == '0) ? DONE : RUN;
        end else
          q_nx = (op == 2'b01) ? shl : (op == 2'b10) ? shr : (op == 2'b11) ? dt : Q;
      RUN: begin
        q_nx = ldir ? shr : shl;
        cnt_nx = cnt - 1'b1;
        state_nx = (cnt == CNTW'(1)) ? DONE : RUN;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      Q <= '0;
      cnt <= '0;
      ldir <= 1'b0;
    end else begin
      state <= state_nx;
      Q <= q_nx;
      cnt <= cnt_nx;
      ldir <= dir_nx;
    end
endmodule

// File: tb/tb_ushift_reg.sv
// tb_ushift_reg: directed and randomized checks of ushift_reg against a behavioural model.
module tb_ushift_reg;
  localparam int SIZE = 8;
  localparam int CNTW = 4;
`ifdef USHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] op = '0;
  logic [SIZE-1:0] dt = '0;
  logic sin = 1'b0, start = 1'b0, dir = 1'b0;
  logic [CNTW-1:0] n = '0;
  logic [SIZE-1:0] Q;
  logic sout, busy, done, zero;
  int checks = 0, errors = 0;
  logic [SIZE-1:0] mq = '0;
  int rem = 0;
  bit mdone = 1'b0, mdir = 1'b0, armed = 1'b0;
  logic mact, m_sout, m_fill;

  ushift_reg #(.SIZE(SIZE), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .op(op), .dt(dt), .sin(sin), .start(start),
    .dir(dir), .n(n), .Q(Q), .sout(sout), .busy(busy), .done(done), .zero(zero)
  );

  always #5 clk = ~clk;

  // Model: rem = shifts still owed, mdone = completion cycle pending
  assign mact = (rem > 0) ? mdir : (op == 2'b10);
  assign m_sout = mact ? mq[0] : mq[SIZE-1];
  assign m_fill = ROT ? m_sout : sin;

  always @(posedge clk)
    if (reset) begin
      mq <= '0;
      rem <= 0;
      mdone <= 1'b0;
      mdir <= 1'b0;
      armed <= 1'b1;
    end else if (rem > 0) begin
      mq <= mdir ? ((mq >> 1) | (SIZE'(m_fill) << (SIZE - 1))) : ((mq << 1) | SIZE'(m_fill));
      rem <= rem - 1;
      mdone <= (rem == 1);
    end else if (mdone)
      mdone <= 1'b0;
    else if (start) begin
      mdir <= dir;
      rem <= int'(n);
      mdone <= (n == '0);
    end else if (op == 2'b01)
      mq <= (mq << 1) | SIZE'(m_fill);
    else if (op == 2'b10)
      mq <= (mq >> 1) | (SIZE'(m_fill) << (SIZE - 1));
    else if (op == 2'b11)
      mq <= dt;

  task automatic check(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (armed) begin
      check("Q", Q, mq);
      check("busy", SIZE'(busy), SIZE'(rem > 0));
      check("done", SIZE'(done), SIZE'(mdone));
      check("zero", SIZE'(zero), SIZE'(mq == '0));
      check("sout", SIZE'(sout), SIZE'(m_sout));
    end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [SIZE-1:0] v);
    op = 2'b11;
    dt = v;
    step();
    op = 2'b00;
  endtask

  // Issues start, then samples until done, counting busy cycles
  task automatic run_auto(input logic d, input logic [CNTW-1:0] cnt, input bit pulse, output int nbusy);
    dir = d;
    n = cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (busy) nbusy++;
      op = (pulse && i < 2) ? 2'b11 : 2'b00;
      dt = 8'h55;
      step();
    end
    op = 2'b00;
    check("done_seen", SIZE'(done), 8'h01);
  endtask

  initial begin
    int nb;
    step();
    step();
    reset = 1'b0;
    check("rst_q", Q, 8'h00);
    check("rst_busy", SIZE'(busy), 8'h00);
    check("rst_done", SIZE'(done), 8'h00);
    check("rst_zero", SIZE'(zero), 8'h01);
    check("rst_sout", SIZE'(sout), 8'h00);
    load(8'hA5);
    check("load_q", Q, 8'hA5);
    check("load_zero", SIZE'(zero), 8'h00);
    check("load_busy", SIZE'(busy | done), 8'h00);
    load(8'h81);
    op = 2'b01;
    sin = 1'b1;
    #1;
    check("shl_sout", SIZE'(sout), 8'h01);
    step();
    op = 2'b00;
    check("shl_q", Q, 8'h03);
    load(8'hF1);
    sin = 1'b0;
    run_auto(1'b1, 4'd3, 1'b0, nb);
    check("r3_busy_cycles", SIZE'(nb), 8'd3);
    check("r3_q", Q, ROT ? 8'h3E : 8'h1E);
    step();
    check("r3_done_clear", SIZE'(done), 8'h00);
    load(8'h5A);
    run_auto(1'b0, 4'd0, 1'b0, nb);
    check("n0_busy_cycles", SIZE'(nb), 8'd0);
    check("n0_q", Q, 8'h5A);
    step();
    check("n0_done_clear", SIZE'(done), 8'h00);
    load(8'hFF);
    run_auto(1'b0, 4'd10, 1'b1, nb);
    check("l10_busy_cycles", SIZE'(nb), 8'd10);
    check("l10_q", Q, ROT ? 8'hFF : 8'h00);
    check("l10_zero", SIZE'(zero), ROT ? 8'h00 : 8'h01);
    step();
    load(8'hFF);
    dir = 1'b0;
    n = 4'd10;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("mid_busy", SIZE'(busy), 8'h01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_q", Q, 8'h00);
    check("mid_rst_busy", SIZE'(busy), 8'h00);
    check("mid_rst_done", SIZE'(done), 8'h00);
    load(8'h96);
    run_auto(1'b0, 4'd8, 1'b0, nb);
    check("rot8_busy_cycles", SIZE'(nb), 8'd8);
    check("rot8_q", Q, ROT ? 8'h96 : 8'h00);
    step();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      op = 2'($urandom);
      dt = 8'($urandom);
      sin = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      dir = 1'($urandom);
      n = 4'($urandom);
      step();
    end
    reset = 1'b0;
    start = 1'b0;
    op = 2'b00;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
